gf180mcu_fd_sc_mcu9t5v0__crc8_ser: RTL
======================================

GF180MCU_FD_SC_MCU9T5V0__CRC8_SER -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__crc8_ser

Interface
REQ-001 SHALL have parameter POLY, default 8'h07, CRC-8 generator polynomial (x^8 term implicit).
REQ-002 SHALL have parameter INIT, default 8'h00, CRC register value loaded at frame start and at reset.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port SOF  input  1  start of frame, sampled on CLK.
REQ-006 SHALL have port DV  input  1  D carries a valid bit this cycle.
REQ-007 SHALL have port D  input  1  serial data bit, MSB first; typically a mismatch stream from an xor2 cell.
REQ-008 SHALL have port EOF  input  1  end of frame; any DV bit in the same cycle is the last bit.
REQ-009 SHALL have port CRC  output  8  current CRC register.
REQ-010 SHALL have port BITCNT  output  7  bits absorbed in the current frame, saturating at 127.
REQ-011 SHALL have port BUSY  output  1  high in ACC state.
REQ-012 SHALL have port DONE  output  1  one-cycle pulse in DONE state.
REQ-013 SHALL have port OK  output  1  valid only while DONE=1; residue check result.

Function
REQ-014 SHALL implement FSM states IDLE, ACC, DONE as registered state.
REQ-015 SHALL update CRC per bit as: fb = CRC[7]^D; CRC <= {CRC[6:0],0} ^ (fb ? POLY : 8'h00).
REQ-016 SHALL, in IDLE with SOF=1, load CRC<=INIT and BITCNT<=0 and enter ACC; a DV bit in the same cycle SHALL be absorbed starting from INIT, with BITCNT<=1.
REQ-017 SHALL, in IDLE with SOF=0, ignore DV, D and EOF; CRC and BITCNT hold.
REQ-018 SHALL, in ACC with DV=1, absorb one bit per cycle and increment BITCNT, saturating at 127.
REQ-019 SHALL, in ACC with SOF=1, abort and restart the frame exactly as REQ-016 (SOF has priority over EOF).
REQ-020 SHALL, in ACC with EOF=1 and SOF=0, absorb any DV bit and enter DONE on the next edge.
REQ-021 SHALL, in DONE, assert DONE=1 for exactly one cycle with OK=(CRC==8'h00); CRC and BITCNT hold; the next state is IDLE, or ACC per REQ-016 if SOF=1.
REQ-022 SHALL drive BUSY=(state==ACC), DONE=(state==DONE) and OK from registered state only (no combinational input-to-output path).

Reset
REQ-023 SHALL, on RN=0, asynchronously force state IDLE, CRC=INIT, BITCNT=0, BUSY=0, DONE=0, OK=0, regardless of CLK, including mid-frame.
REQ-024 SHALL resume normal operation on the first rising CLK edge after RN deasserts; no partial frame survives reset.

Configuration
REQ-025 SHALL, with GF180MCU_FD_SC_MCU9T5V0__CRC8_SER_LENERR_EN defined, add output LENERR (1 bit), asserted only in DONE when BITCNT==0 or BITCNT[2:0]!=0, with OK forced to 0 whenever LENERR=1; LENERR resets to 0.
REQ-026 SHALL, without that macro, omit the LENERR port and logic, and compute OK solely as CRC==8'h00.

Structure
REQ-027 SHALL put the state enum, default POLY/INIT constants and the one-bit CRC step function in shared package gf180mcu_fd_sc_mcu9t5v0__crc8_pkg.
REQ-028 SHALL instantiate one combinational sub-module gf180mcu_fd_sc_mcu9t5v0__crc8_step (inputs crc, d, poly; output next crc) for the LFSR update.

Verification
REQ-029 SHALL test: SOF+DV with byte 8'h01 MSB first, EOF on last bit -> CRC=8'h07, BITCNT=8, DONE one cycle, OK=0.
REQ-030 SHALL test: frame 8'h01,8'h07 (16 bits) -> CRC=8'h00, BITCNT=16, OK=1 (LENERR=0 when enabled).
REQ-031 SHALL test: RN pulsed low after 5 bits of a frame -> CRC=8'h00, BITCNT=0, BUSY=0 immediately, without waiting for a CLK edge.
REQ-032 SHALL test: SOF reasserted mid-frame after 3 bits, then 8'h01 -> CRC=8'h07, BITCNT=8 (first 3 bits discarded).
REQ-033 SHALL test: 130 DV bits of zero then EOF -> BITCNT=127 saturated, CRC=8'h00, OK=1 without macro, OK=0 and LENERR=1 with macro.
REQ-034 SHALL test: EOF with DV=0 in ACC, and SOF in the DONE cycle -> DONE pulses once, next cycle BUSY=1 and CRC=INIT.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__crc8_pkg.sv
// Shared definitions for the serial CRC-8 checker: FSM states, default
// polynomial/initial value and the single-bit LFSR step.
package gf180mcu_fd_sc_mcu9t5v0__crc8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
  localparam logic [7:0] CRC8_INIT_DEFAULT = 8'h00;
  localparam logic [6:0] BITCNT_MAX        = 7'd127;

  // MSB-first shift; the x^8 term of the polynomial is implicit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic       d,
                                           input logic [7:0] poly);
    logic fb;
    fb = crc[7] ^ d;
    return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__crc8_step.sv
// Combinational one-bit CRC-8 LFSR update.
module gf180mcu_fd_sc_mcu9t5v0__crc8_step
  import gf180mcu_fd_sc_mcu9t5v0__crc8_pkg::*;
(
  input  logic [7:0] crc,
  input  logic       d,
  input  logic [7:0] poly,
  output logic [7:0] crc_next
);

  assign crc_next = crc8_step(crc, d, poly);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__crc8_ser.sv
// Serial CRC-8 frame accumulator with residue check (IDLE/ACC/DONE FSM).
// Optional LENERR output enabled by GF180MCU_FD_SC_MCU9T5V0__CRC8_SER_LENERR_EN.
module gf180mcu_fd_sc_mcu9t5v0__crc8_ser
  import gf180mcu_fd_sc_mcu9t5v0__crc8_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_DEFAULT,
  parameter logic [7:0] INIT = CRC8_INIT_DEFAULT
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic       SOF,
  input  logic       DV,
  input  logic       D,
  input  logic       EOF,
  output logic [7:0] CRC,
  output logic [6:0] BITCNT,
  output logic       BUSY,
  output logic       DONE,
  output logic       OK
`ifdef GF180MCU_FD_SC_MCU9T5V0__CRC8_SER_LENERR_EN
  ,
  output logic       LENERR
`endif
);

  state_e     state_q, state_d;
  logic [7:0] crc_q, crc_d;
  logic [6:0] bitcnt_q, bitcnt_d;
  logic [7:0] step_in, step_out;
  logic [6:0] bitcnt_inc;
  logic       crc_zero;

  // A starting frame absorbs its first bit from INIT, not from the old residue.
  assign step_in    = SOF ? INIT : crc_q;
  assign bitcnt_inc = (bitcnt_q == BITCNT_MAX) ? bitcnt_q : bitcnt_q + 7'd1;

  gf180mcu_fd_sc_mcu9t5v0__crc8_step u_step (
    .crc      (step_in),
    .d        (D),
    .poly     (POLY),
    .crc_next (step_out)
  );

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q  <= ST_IDLE;
      crc_q    <= INIT;
      bitcnt_q <= 7'd0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    bitcnt_d = bitcnt_q;
    if (SOF) begin
      state_d  = ST_ACC;
      crc_d    = DV ? step_out : INIT;
      bitcnt_d = DV ? 7'd1 : 7'd0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_ACC: begin
          if (DV) begin
            crc_d    = step_out;
            bitcnt_d = bitcnt_inc;
          end
          if (EOF) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign crc_zero = (crc_q == 8'h00);
  assign CRC      = crc_q;
  assign BITCNT   = bitcnt_q;
  assign BUSY     = (state_q == ST_ACC);
  assign DONE     = (state_q == ST_DONE);

`ifdef GF180MCU_FD_SC_MCU9T5V0__CRC8_SER_LENERR_EN
  // Frames must be a non-zero whole number of bytes.
  assign LENERR = DONE && ((bitcnt_q == 7'd0) || (bitcnt_q[2:0] != 3'd0));
  assign OK     = DONE && crc_zero && !LENERR;
`else
  assign OK     = DONE && crc_zero;
`endif

endmodule
